// File: rtl/virtual_ds2431_mem_cmd_dispatcher_if.sv
// Byte-link, engine-fabric and status bundle for the DS2431 memory-function sequencer.
// Latency: wires only. Backpressure: none; the link handshake is transTrig out, ByteTransDone back.
// master = dispatcher side, slave = link layer / engines / testbench side.
interface virtual_ds2431_mem_cmd_dispatcher_if;
  // line / ROM layer -> dispatcher
  logic        endCmd;         // bus reset / abort pulse
  logic        startTrig;      // ROM layer hands the bus over
  logic [7:0]  receiveDat;     // received byte, valid with ByteTransDone
  logic        ByteTransDone;  // link finished current byte
  // dispatcher -> link
  logic [7:0]  sentDat;
  logic        transTrig;
  logic        nRxTx;          // 0 = receive, 1 = transmit
  // dispatcher -> engines
  logic [7:0]  TA1;
  logic [7:0]  TA2;
  logic [3:0]  cmdRunTrig;     // one-hot engine start
  // engines -> dispatcher (engine i in lane i)
  logic [31:0] eSentDat;
  logic [3:0]  eTransTrig;
  logic [3:0]  eNRxTx;
  logic [3:0]  eCmdDone;
  logic [3:0]  eCmdFailed;
  // status
  logic        busy;
  logic        memDone;
  logic        memFailed;

  modport master (
    input  endCmd, startTrig, receiveDat, ByteTransDone,
    input  eSentDat, eTransTrig, eNRxTx, eCmdDone, eCmdFailed,
    output sentDat, transTrig, nRxTx, TA1, TA2, cmdRunTrig,
    output busy, memDone, memFailed
  );

  modport slave (
    output endCmd, startTrig, receiveDat, ByteTransDone,
    output eSentDat, eTransTrig, eNRxTx, eCmdDone, eCmdFailed,
    input  sentDat, transTrig, nRxTx, TA1, TA2, cmdRunTrig,
    input  busy, memDone, memFailed
  );
endinterface

// File: rtl/virtual_ds2431_mem_cmd_dispatcher.sv
// Memory-function sequencer: receives command + TA1/TA2 bytes, starts one sub-command engine, muxes the byte link to it.
// Latency: startTrig -> transTrig 1 cycle; last ByteTransDone -> cmdRunTrig next cycle; engine done -> memDone next cycle.
// Backpressure: waits indefinitely per byte on ByteTransDone, bounded by a watchdog of 2^WDOG_W-1 cycles; endCmd aborts anywhere.
// Ports: clk, nRst (async active-low); bus (master modport) carries link, engine fabric, TA bytes and status.
module virtual_ds2431_mem_cmd_dispatcher #(
  parameter logic [7:0] CMD_WRITE_SP = 8'h0F,
  parameter logic [7:0] CMD_READ_SP  = 8'hAA,
  parameter logic [7:0] CMD_COPY_SP  = 8'h55,
  parameter logic [7:0] CMD_READ_MEM = 8'hF0,
  parameter int         WDOG_W       = 20
) (
  input logic clk,
  input logic nRst,
  virtual_ds2431_mem_cmd_dispatcher_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RX_CMD, ST_W_CMD, ST_RX_TA1, ST_W_TA1,
    ST_RX_TA2, ST_W_TA2, ST_RUN, ST_FAIL
  } state_t;

  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
  localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);

  state_t            state, stateNext;
  logic [1:0]        sel;
  logic [7:0]        ta1, ta2;
  logic [WDOG_W-1:0] wdog;
  logic              wdogExpire;
  logic              watched;
  logic              runFirst;
  logic              memDoneQ;
  logic              cmdNeedsAddr;
  logic              engDone, engFailed;

  assign cmdNeedsAddr = (bus.receiveDat == CMD_WRITE_SP) ||
                        (bus.receiveDat == CMD_COPY_SP)  ||
                        (bus.receiveDat == CMD_READ_MEM);

  assign watched = (state == ST_W_CMD) || (state == ST_W_TA1) ||
                   (state == ST_W_TA2) || (state == ST_RUN);

  // The counter would step onto all-ones at this edge: leave the state now,
  // so a silent link holds a wait state for exactly 2^WDOG_W-1 cycles.
  assign wdogExpire = watched && (wdog == (WDOG_MAX - WDOG_ONE));

  assign engDone   = bus.eCmdDone[sel];
  assign engFailed = bus.eCmdFailed[sel];

  function automatic logic [1:0] engineIdx(input logic [7:0] op);
    if (op == CMD_READ_SP)       return 2'd1;
    else if (op == CMD_COPY_SP)  return 2'd2;
    else if (op == CMD_READ_MEM) return 2'd3;
    else                         return 2'd0;
  endfunction

  // state register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:   if (bus.startTrig) stateNext = ST_RX_CMD;
      ST_RX_CMD: stateNext = ST_W_CMD;
      ST_W_CMD: begin
        if (bus.ByteTransDone) begin
          if (cmdNeedsAddr)                        stateNext = ST_RX_TA1;
          else if (bus.receiveDat == CMD_READ_SP)  stateNext = ST_RUN;
          else                                     stateNext = ST_FAIL;
        end else if (wdogExpire) begin
          stateNext = ST_FAIL;
        end
      end
      ST_RX_TA1: stateNext = ST_W_TA1;
      ST_W_TA1: begin
        if (bus.ByteTransDone)   stateNext = ST_RX_TA2;
        else if (wdogExpire)     stateNext = ST_FAIL;
      end
      ST_RX_TA2: stateNext = ST_W_TA2;
      ST_W_TA2: begin
        if (bus.ByteTransDone)   stateNext = ST_RUN;
        else if (wdogExpire)     stateNext = ST_FAIL;
      end
      ST_RUN: begin
        // failure beats a simultaneous done
        if (engFailed)                                stateNext = ST_FAIL;
        else if (engDone)                             stateNext = ST_IDLE;
        else if (!bus.ByteTransDone && wdogExpire)    stateNext = ST_FAIL;
      end
      ST_FAIL:   stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
    // abort overrides every transition, including a same-cycle start or byte
    if (bus.endCmd) stateNext = ST_IDLE;
  end

  // datapath: address latches, engine select, watchdog, registered pulses
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ta1      <= '0;
      ta2      <= '0;
      sel      <= '0;
      wdog     <= '0;
      runFirst <= 1'b0;
      memDoneQ <= 1'b0;
    end else begin
      memDoneQ <= (state == ST_RUN) && !bus.endCmd && !engFailed && engDone;
      runFirst <= (stateNext == ST_RUN) && (state != ST_RUN);

      if (bus.ByteTransDone && !bus.endCmd) begin
        case (state)
          ST_W_CMD: sel <= engineIdx(bus.receiveDat);
          ST_W_TA1: ta1 <= bus.receiveDat;
          ST_W_TA2: ta2 <= bus.receiveDat;
          default:  ;
        endcase
      end

      // restart on every state change and on link activity; saturate otherwise
      if (!watched || (stateNext != state) || bus.ByteTransDone) wdog <= '0;
      else if (wdog != WDOG_MAX)                                 wdog <= wdog + WDOG_ONE;
    end
  end

  // outputs
  always_comb begin
    bus.sentDat    = '0;
    bus.transTrig  = 1'b0;
    bus.nRxTx      = 1'b0;
    bus.cmdRunTrig = '0;
    case (state)
      ST_RX_CMD, ST_RX_TA1, ST_RX_TA2: bus.transTrig = 1'b1;
      ST_RUN: begin
        bus.sentDat   = bus.eSentDat[{sel, 3'b000} +: 8];
        bus.transTrig = bus.eTransTrig[sel];
        bus.nRxTx     = bus.eNRxTx[sel];
        if (runFirst) bus.cmdRunTrig = 4'b0001 << sel;
      end
      default: ;
    endcase
  end

  assign bus.TA1       = ta1;
  assign bus.TA2       = ta2;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.memDone   = memDoneQ;
  assign bus.memFailed = (state == ST_FAIL);

endmodule

// File: tb/tb_virtual_ds2431_mem_cmd_dispatcher.sv
// Bench for the DS2431 memory-function sequencer: vector table of whole transactions,
// randomized transactions against a transaction-level model, and hand-written corner sequences.
module tb_virtual_ds2431_mem_cmd_dispatcher;
  localparam int WDOG_W = 4;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  virtual_ds2431_mem_cmd_dispatcher_if bus();

  virtual_ds2431_mem_cmd_dispatcher #(.WDOG_W(WDOG_W)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // pulse monitor, sampled on the falling edge
  int         runCnt  = 0;
  int         doneCnt = 0;
  int         failCnt = 0;
  logic [3:0] runLast = '0;
  always @(negedge clk) begin
    if (bus.cmdRunTrig != 4'b0) begin
      runCnt  <= runCnt + 1;
      runLast <= bus.cmdRunTrig;
    end
    if (bus.memDone)   doneCnt <= doneCnt + 1;
    if (bus.memFailed) failCnt <= failCnt + 1;
  end

  // model copy of the latched address bytes
  logic [7:0] mTA1, mTA2;

  typedef struct {
    logic [7:0] op, t1, t2;
    int         abortAt;   // -1 none, 0..2 byte index aborted, 3 abort in RUN
    int         resp;      // 0 done, 1 failed, 2 done+failed together
    logic [3:0] eRun;
    int         eDone, eFail;
    logic [7:0] eTA1, eTA2;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Plays the link and the engines for one memory-function transaction.
  task automatic doTxn(input logic [7:0] op, input logic [7:0] t1, input logic [7:0] t2,
                       input int abortAt, input int resp, input int dly);
    logic [7:0]  bytes[3];
    logic        needs, legal, aborted;
    int          nb, idx;
    logic [31:0] es;
    logic [3:0]  et, en;
    bytes[0] = op; bytes[1] = t1; bytes[2] = t2;
    needs = (op == 8'h0F) || (op == 8'h55) || (op == 8'hF0);
    legal = needs || (op == 8'hAA);
    nb    = needs ? 3 : 1;
    idx   = (op == 8'hAA) ? 1 : (op == 8'h55) ? 2 : (op == 8'hF0) ? 3 : 0;
    aborted = 1'b0;
    bus.startTrig = 1'b1;
    tick();
    bus.startTrig = 1'b0;
    for (int k = 0; k < nb && !aborted; k++) begin
      check("rx_trig", 32'({bus.transTrig, bus.nRxTx, bus.busy}), 32'b101);
      tick();
      check("rx_pulse", 32'(bus.transTrig), 32'd0);
      repeat (dly) tick();
      bus.receiveDat    = bytes[k];
      bus.ByteTransDone = 1'b1;
      bus.endCmd        = (k == abortAt);
      tick();
      bus.ByteTransDone = 1'b0;
      bus.endCmd        = 1'b0;
      bus.receiveDat    = 8'h00;
      if (k == abortAt) aborted = 1'b1;
    end
    if (legal && !aborted) begin
      es = $urandom; et = 4'($urandom); en = 4'($urandom);
      bus.eSentDat = es; bus.eTransTrig = et; bus.eNRxTx = en;
      #1;
      check("mux_dat", 32'(bus.sentDat), 32'(es[8*idx +: 8]));
      check("mux_trig", 32'(bus.transTrig), 32'(et[idx]));
      check("mux_dir", 32'(bus.nRxTx), 32'(en[idx]));
      tick();
      bus.eSentDat = '0; bus.eTransTrig = '0; bus.eNRxTx = '0;
      // other engines' done/failed must be ignored
      bus.eCmdDone   = ~(4'b0001 << idx);
      bus.eCmdFailed = ~(4'b0001 << idx);
      tick();
      check("noise_busy", 32'(bus.busy), 32'd1);
      bus.eCmdDone   = 4'(resp != 1) << idx;
      bus.eCmdFailed = 4'(resp != 0) << idx;
      bus.endCmd     = (abortAt == 3);
      tick();
      bus.eCmdDone = '0; bus.eCmdFailed = '0; bus.endCmd = 1'b0;
    end
    repeat (3) tick();
  endtask

  // Transaction-level expectation from opcode, abort point and engine response.
  task automatic model(input logic [7:0] op, input logic [7:0] t1, input logic [7:0] t2,
                       input int abortAt, input int resp,
                       output logic [3:0] eRun, output int eDone, output int eFail);
    logic needs, legal;
    int   nb;
    needs = (op == 8'h0F) || (op == 8'h55) || (op == 8'hF0);
    legal = needs || (op == 8'hAA);
    nb    = needs ? 3 : 1;
    eRun = '0; eDone = 0; eFail = 0;
    if (abortAt >= 0 && abortAt < nb) begin
      if (needs && abortAt == 2) mTA1 = t1;
      return;
    end
    if (!legal) begin
      eFail = 1;
      return;
    end
    if (needs) begin
      mTA1 = t1;
      mTA2 = t2;
    end
    case (op)
      8'h0F:   eRun = 4'b0001;
      8'hAA:   eRun = 4'b0010;
      8'h55:   eRun = 4'b0100;
      default: eRun = 4'b1000;
    endcase
    if (abortAt == 3) return;
    if (resp == 0) eDone = 1;
    else           eFail = 1;
  endtask

  task automatic runAndCheck(input string tag, input logic [7:0] op, input logic [7:0] t1,
                             input logic [7:0] t2, input int abortAt, input int resp,
                             input logic [3:0] eRun, input int eDone, input int eFail,
                             input logic [7:0] eTA1, input logic [7:0] eTA2);
    int r0, d0, f0;
    r0 = runCnt; d0 = doneCnt; f0 = failCnt;
    doTxn(op, t1, t2, abortAt, resp, $urandom_range(0, 6));
    check({tag, "_run_cnt"}, 32'(runCnt - r0), 32'(eRun != 4'b0));
    check({tag, "_run_vec"}, 32'((runCnt != r0) ? runLast : 4'b0), 32'(eRun));
    check({tag, "_done"}, 32'(doneCnt - d0), 32'(eDone));
    check({tag, "_fail"}, 32'(failCnt - f0), 32'(eFail));
    check({tag, "_ta1"}, 32'(bus.TA1), 32'(eTA1));
    check({tag, "_ta2"}, 32'(bus.TA2), 32'(eTA2));
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic enterRunAA();
    bus.startTrig = 1'b1;
    tick();
    bus.startTrig = 1'b0;
    tick();
    bus.receiveDat = 8'hAA;
    bus.ByteTransDone = 1'b1;
    tick();
    bus.ByteTransDone = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] op, t1, t2;
    logic [3:0] eRun;
    int         eDone, eFail, abortAt, resp, n, stray;

    //                op     t1     t2   abort resp  run     done fail  TA1    TA2
    tbl[0] = '{8'h0F, 8'h10, 8'h00, -1, 0, 4'b0001, 1, 0, 8'h10, 8'h00};
    tbl[1] = '{8'hAA, 8'hEE, 8'hEE, -1, 0, 4'b0010, 1, 0, 8'h10, 8'h00};
    tbl[2] = '{8'h3C, 8'hEE, 8'hEE, -1, 0, 4'b0000, 0, 1, 8'h10, 8'h00};
    tbl[3] = '{8'hF0, 8'h22, 8'h33,  2, 0, 4'b0000, 0, 0, 8'h22, 8'h00};
    tbl[4] = '{8'h55, 8'h44, 8'h55, -1, 2, 4'b0100, 0, 1, 8'h44, 8'h55};
    tbl[5] = '{8'hF0, 8'h66, 8'h77, -1, 1, 4'b1000, 0, 1, 8'h66, 8'h77};
    tbl[6] = '{8'h55, 8'h01, 8'h02,  3, 0, 4'b0100, 0, 0, 8'h01, 8'h02};

    bus.endCmd = 1'b0; bus.startTrig = 1'b0; bus.receiveDat = '0; bus.ByteTransDone = 1'b0;
    bus.eSentDat = '0; bus.eTransTrig = '0; bus.eNRxTx = '0; bus.eCmdDone = '0; bus.eCmdFailed = '0;

    // reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_link", 32'({bus.sentDat, bus.transTrig, bus.nRxTx}), 32'd0);
    check("rst_status", 32'({bus.busy, bus.memDone, bus.memFailed, bus.cmdRunTrig}), 32'd0);
    check("rst_ta", 32'({bus.TA1, bus.TA2}), 32'd0);
    nRst = 1'b1;
    tick();

    // vector table
    for (int i = 0; i < 7; i++) begin
      runAndCheck($sformatf("vec%0d", i), tbl[i].op, tbl[i].t1, tbl[i].t2, tbl[i].abortAt,
                  tbl[i].resp, tbl[i].eRun, tbl[i].eDone, tbl[i].eFail, tbl[i].eTA1, tbl[i].eTA2);
    end

    // ByteTransDone in IDLE does nothing
    bus.receiveDat = 8'h0F;
    bus.ByteTransDone = 1'b1;
    tick();
    bus.ByteTransDone = 1'b0;
    check("idle_btd_busy", 32'(bus.busy), 32'd0);
    check("idle_btd_trig", 32'(bus.transTrig), 32'd0);
    tick();
    check("idle_btd_quiet", 32'({bus.busy, bus.transTrig, bus.cmdRunTrig}), 32'd0);

    // randomized transactions against the model
    mTA1 = 8'h01;
    mTA2 = 8'h02;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = 8'h0F;
        1: op = 8'hAA;
        2: op = 8'h55;
        3: op = 8'hF0;
        default: op = 8'($urandom);
      endcase
      t1 = 8'($urandom);
      t2 = 8'($urandom);
      abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      resp = $urandom_range(0, 2);
      model(op, t1, t2, abortAt, resp, eRun, eDone, eFail);
      runAndCheck($sformatf("rnd%0d", i), op, t1, t2, abortAt, resp, eRun, eDone, eFail, mTA1, mTA2);
    end

    // watchdog in W_CMD; a startTrig while busy must not restart the sequence
    bus.startTrig = 1'b1;
    tick();
    bus.startTrig = 1'b0;
    tick();
    n = 0;
    stray = 0;
    while (!bus.memFailed && n < 40) begin
      bus.startTrig = (n == 3);
      if (bus.transTrig) stray++;
      tick();
      n++;
    end
    bus.startTrig = 1'b0;
    check("wdog_cmd_cycles", 32'(n), 32'd15);
    check("wdog_cmd_silent", 32'(stray), 32'd0);
    check("wdog_cmd_fail_trig", 32'(bus.transTrig), 32'd0);
    tick();
    check("wdog_cmd_idle", 32'({bus.busy, bus.memFailed}), 32'd0);

    // watchdog in RUN, restarted by one ByteTransDone after 10 cycles
    enterRunAA();
    n = 0;
    while (!bus.memFailed && n < 60) begin
      bus.ByteTransDone = (n == 9);
      tick();
      n++;
    end
    bus.ByteTransDone = 1'b0;
    check("wdog_run_cycles", 32'(n), 32'd25);
    tick();
    check("wdog_run_idle", 32'(bus.busy), 32'd0);

    // asynchronous reset in RUN with a done pending
    enterRunAA();
    bus.eCmdDone = 4'b0010;
    #1;
    nRst = 1'b0;
    #1;
    check("arst_status", 32'({bus.busy, bus.memDone, bus.memFailed, bus.cmdRunTrig}), 32'd0);
    check("arst_ta", 32'({bus.TA1, bus.TA2}), 32'd0);
    tick();
    bus.eCmdDone = '0;
    nRst = 1'b1;
    tick();
    check("arst_after", 32'({bus.busy, bus.memDone, bus.transTrig}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
